// File: rtl/divider32_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package divider32_seq_pkg;

    localparam int DIV_N = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/divider32_seq_if.sv
// Start/busy/done handshake and operand/result bundle between the control
// side (master) and the divider (slave).
interface divider32_seq_if #(parameter int N = 32);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;

    modport master (output start, a, b, input busy, done, q, r, dbz);
    modport slave  (input start, a, b, output busy, done, q, r, dbz);
endinterface

// File: rtl/divider32_seq_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] p,
    input  logic         dbit,
    input  logic [N-1:0] b,
    output logic [N-1:0] p_next,
    output logic         qbit
);

    logic [N:0]   t_s;
    logic [N+1:0] diff_s;
    logic         borrow_s;

    // Trial value is N+1 bits wide; the extra top bit of diff_s is the borrow.
    always_comb begin
        t_s      = {p, dbit};
        diff_s   = {1'b0, t_s} - {2'b00, b};
        borrow_s = diff_s[N+1];
    end

    // Restore on borrow, otherwise keep the difference (which is < b, so fits N bits).
    always_comb begin
        p_next = {N{1'b0}};
        qbit   = 1'b0;
        if (borrow_s) begin
            p_next = t_s[N-1:0];
            qbit   = 1'b0;
        end else begin
            p_next = diff_s[N-1:0];
            qbit   = 1'b1;
        end
    end

endmodule

// File: rtl/divider32_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock:
// a = q*b + r with r < b; b == 0 completes immediately with dbz set.
module divider32_seq
    import divider32_seq_pkg::*;
#(
    parameter int N = DIV_N
) (
    input logic             clk,
    input logic             rst,
    divider32_seq_if.slave  bus
);

    localparam int CW = $clog2(N);

    div_state_e    state_r;
    logic [CW-1:0] cnt_r;
    logic [N-1:0]  d_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  p_r;
    logic [N-1:0]  quo_r;
    logic [N-1:0]  q_r;
    logic [N-1:0]  r_r;
    logic          dbz_r;
    logic          busy_r;
    logic          done_r;

    logic [N-1:0]  p_next_s;
    logic          qbit_s;
    logic [N-1:0]  quo_next_s;

    div_step #(.N(N)) u_step (
        .p      (p_r),
        .dbit   (d_r[N-1]),
        .b      (b_r),
        .p_next (p_next_s),
        .qbit   (qbit_s)
    );

    assign quo_next_s = {quo_r[N-2:0], qbit_s};

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.q    = q_r;
    assign bus.r    = r_r;
    assign bus.dbz  = dbz_r;

    // Divider FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DIV_IDLE;
            cnt_r   <= {CW{1'b0}};
            d_r     <= {N{1'b0}};
            b_r     <= {N{1'b0}};
            p_r     <= {N{1'b0}};
            quo_r   <= {N{1'b0}};
            q_r     <= {N{1'b0}};
            r_r     <= {N{1'b0}};
            dbz_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE, DIV_DONE: begin
                    if (bus.start) begin
                        d_r   <= bus.a;
                        b_r   <= bus.b;
                        p_r   <= {N{1'b0}};
                        quo_r <= {N{1'b0}};
                        if (bus.b == {N{1'b0}}) begin
                            // Divide by zero finishes in one edge with all-ones quotient.
                            state_r <= DIV_DONE;
                            q_r     <= {N{1'b1}};
                            r_r     <= bus.a;
                            dbz_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= DIV_RUN;
                            cnt_r   <= CW'(N - 1);
                            dbz_r   <= 1'b0;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= DIV_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                DIV_RUN: begin
                    d_r   <= {d_r[N-2:0], 1'b0};
                    p_r   <= p_next_s;
                    quo_r <= quo_next_s;
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= DIV_DONE;
                        q_r     <= quo_next_s;
                        r_r     <= p_next_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r  <= cnt_r - CW'(1);
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= DIV_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider32_seq.sv
// Directed and randomized self-checking bench for divider32_seq.
module tb_divider32_seq;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    divider32_seq_if #(.N(32)) bus ();

    divider32_seq #(.N(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one op, wait for done (bounded), check latency, results and pulse width.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        int edges;
        int exp_lat;
        exp_lat = (tb_v == 32'd0) ? 1 : 33;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        @(negedge clk);
        bus.start = 1'b0;
        edges = 1;
        if (tb_v != 32'd0) check({tag, "_busy"}, {63'd0, bus.busy}, 64'd1);
        while (bus.done !== 1'b1 && edges < 64) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_lat"}, 64'(edges), 64'(exp_lat));
        check({tag, "_q"}, {32'd0, bus.q}, {32'd0, eq});
        check({tag, "_r"}, {32'd0, bus.r}, {32'd0, er});
        check({tag, "_dbz"}, {63'd0, bus.dbz}, {63'd0, edbz});
        check({tag, "_busy_done"}, {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        check({tag, "_pulse"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        int edges;
        int done_seen;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_q", {32'd0, bus.q}, 64'd0);
        check("rst_r", {32'd0, bus.r}, 64'd0);
        check("rst_dbz", {63'd0, bus.dbz}, 64'd0);
        rst = 1'b0;

        run_op("t1_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_op("t2_max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("t2_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_op("t3_3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
        run_op("t3_dbz", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_op("t3_clr_dbz", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

        // Start ignored while busy, then a chained start in the DONE cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        edges = 1;
        while (bus.done !== 1'b1 && edges < 64) begin
            if (edges == 9) begin
                bus.start = 1'b1;
                bus.a     = 32'd9;
                bus.b     = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        check("t4_lat", 64'(edges), 64'd33);
        check("t4_q", {32'd0, bus.q}, 64'd14);
        check("t4_r", {32'd0, bus.r}, 64'd2);
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        check("t4_chain_done_low", {63'd0, bus.done}, 64'd0);
        check("t4_chain_busy", {63'd0, bus.busy}, 64'd1);
        edges = 1;
        while (bus.done !== 1'b1 && edges < 64) begin
            @(negedge clk);
            edges++;
        end
        check("t4_chain_lat", 64'(edges), 64'd33);
        check("t4_chain_q", {32'd0, bus.q}, 64'd3);
        check("t4_chain_r", {32'd0, bus.r}, 64'd0);

        // Reset mid-operation aborts with no done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", {63'd0, bus.busy}, 64'd0);
        check("t5_done", {63'd0, bus.done}, 64'd0);
        check("t5_q", {32'd0, bus.q}, 64'd0);
        check("t5_r", {32'd0, bus.r}, 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("t5_no_done", 64'(done_seen), 64'd0);
        run_op("t5_50_6", 32'd50, 32'd6, 32'd8, 32'd2, 1'b0);

        // Randomized operands against a behavioural reference.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == 32'd0) rb = 32'd1;
            run_op("rand", ra, rb, ra / rb, ra % rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
